// File: rtl/execute_muldiv_pkg.sv
// rtl/execute_muldiv_pkg.sv - RV32M funct3 codes, FSM states and operand-sign helpers
package execute_muldiv_pkg;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_MULHU  = 3'd3;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_DIVU   = 3'd5;
   localparam logic [2:0] F_REM    = 3'd6;
   localparam logic [2:0] F_REMU   = 3'd7;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_t;

   function automatic logic rs1_is_signed(input logic [2:0] f);
      return (f == F_MULH) || (f == F_MULHSU) || (f == F_DIV) || (f == F_REM);
   endfunction

   function automatic logic rs2_is_signed(input logic [2:0] f);
      return (f == F_MULH) || (f == F_DIV) || (f == F_REM);
   endfunction

endpackage

// File: rtl/execute_muldiv_step.sv
// rtl/execute_muldiv_step.sv - one iteration of shift-add multiply or restoring divide
// In multiply mode {hi,lo} is the accumulator with the multiplier in lo; in divide mode hi is the
// partial remainder and lo shifts the dividend out while quotient bits shift in.
module execute_muldiv_step #(
   parameter int DWIDTH         = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              mode_div,
   input  logic [DWIDTH:0]   hi,
   input  logic [DWIDTH-1:0] lo,
   input  logic [DWIDTH-1:0] opnd,
   output logic [DWIDTH:0]   hi_next,
   output logic [DWIDTH-1:0] lo_next
);

   logic [DWIDTH:0]   h;
   logic [DWIDTH-1:0] l;
   logic [DWIDTH:0]   sum;
   logic [DWIDTH+1:0] trial;

   always_comb begin
      h     = hi;
      l     = lo;
      sum   = '0;
      trial = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         if (mode_div) begin
            h     = {h[DWIDTH-1:0], l[DWIDTH-1]};
            l     = {l[DWIDTH-2:0], 1'b0};
            trial = {1'b0, h} - {2'b00, opnd};
            // Non-negative trial difference means the divisor fits: keep it, set quotient bit.
            if (!trial[DWIDTH+1]) begin
               h    = trial[DWIDTH:0];
               l[0] = 1'b1;
            end
         end else begin
            sum = h + {1'b0, (l[0] ? opnd : {DWIDTH{1'b0}})};
            l   = {sum[0], l[DWIDTH-1:1]};
            h   = {1'b0, sum[DWIDTH:1]};
         end
      end
      hi_next = h;
      lo_next = l;
   end

endmodule

// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - multi-cycle RV32M multiply/divide execute unit
// Works on operand magnitudes and sign-corrects the result on the final iteration.
module execute_muldiv
   import execute_muldiv_pkg::*;
#(
   parameter int DWIDTH         = 32,
   parameter int AWIDTH         = 5,
   parameter int PC_WIDTH       = 32,
   parameter int FUNCT_WIDTH    = 3,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                   ex_clk,
   input  logic                   ex_rst,
   input  logic                   ex_i_ce,
   input  logic                   ex_i_flush,
   input  logic                   ex_i_stall,
   input  logic [FUNCT_WIDTH-1:0] ex_i_funct3,
   input  logic [DWIDTH-1:0]      ex_i_data_rs1,
   input  logic [DWIDTH-1:0]      ex_i_data_rs2,
   input  logic [AWIDTH-1:0]      ex_i_addr_rd,
   input  logic [PC_WIDTH-1:0]    ex_i_pc,
   output logic                   ex_o_busy,
   output logic                   ex_o_valid,
   output logic                   ex_o_we_reg,
   output logic [DWIDTH-1:0]      ex_o_data_rd,
   output logic [AWIDTH-1:0]      ex_o_addr_rd,
   output logic [PC_WIDTH-1:0]    ex_o_pc
);

   localparam int N  = DWIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N) + 1;

   md_state_t         state;
   logic [2:0]        funct;
   logic [CW-1:0]     count;
   logic [DWIDTH:0]   acc_hi;
   logic [DWIDTH-1:0] acc_lo;
   logic [DWIDTH-1:0] opnd;
   logic              neg_q;
   logic              neg_r;
   logic              fast;

   logic [2:0]          f_in;
   logic                a_neg, b_neg, is_div, b_zero, ovf;
   logic [DWIDTH-1:0]   mag_a, mag_b, fast_res;
   logic [DWIDTH:0]     step_hi;
   logic [DWIDTH-1:0]   step_lo;
   logic [2*DWIDTH-1:0] product, prod_s;
   logic [DWIDTH-1:0]   q_s, r_s, mul_res, div_res;
   logic                last;

   assign f_in   = ex_i_funct3[2:0];
   assign a_neg  = rs1_is_signed(f_in) & ex_i_data_rs1[DWIDTH-1];
   assign b_neg  = rs2_is_signed(f_in) & ex_i_data_rs2[DWIDTH-1];
   assign mag_a  = a_neg ? -ex_i_data_rs1 : ex_i_data_rs1;
   assign mag_b  = b_neg ? -ex_i_data_rs2 : ex_i_data_rs2;
   assign is_div = f_in[2];
   assign b_zero = (ex_i_data_rs2 == '0);
   assign ovf    = ((f_in == F_DIV) || (f_in == F_REM)) &&
                   (ex_i_data_rs1 == {1'b1, {(DWIDTH-1){1'b0}}}) && (ex_i_data_rs2 == '1);
   // funct3 bit 1 separates REM/REMU from DIV/DIVU
   assign fast_res = b_zero ? (f_in[1] ? ex_i_data_rs1 : '1)
                            : (f_in[1] ? '0 : ex_i_data_rs1);

   execute_muldiv_step #(
      .DWIDTH         (DWIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_step (
      .mode_div (state == MD_DIV),
      .hi       (acc_hi),
      .lo       (acc_lo),
      .opnd     (opnd),
      .hi_next  (step_hi),
      .lo_next  (step_lo)
   );

   assign product = {step_hi[DWIDTH-1:0], step_lo};
   assign prod_s  = neg_q ? -product : product;
   assign mul_res = (funct == F_MUL) ? prod_s[DWIDTH-1:0] : prod_s[2*DWIDTH-1:DWIDTH];
   assign q_s     = neg_q ? -step_lo : step_lo;
   assign r_s     = neg_r ? -step_hi[DWIDTH-1:0] : step_hi[DWIDTH-1:0];
   assign div_res = funct[1] ? r_s : q_s;
   assign last    = (count == CW'(N - 1));

   assign ex_o_busy = (state != MD_IDLE);

   always_ff @(posedge ex_clk or posedge ex_rst) begin
      if (ex_rst) begin
         state        <= MD_IDLE;
         funct        <= '0;
         count        <= '0;
         acc_hi       <= '0;
         acc_lo       <= '0;
         opnd         <= '0;
         neg_q        <= 1'b0;
         neg_r        <= 1'b0;
         fast         <= 1'b0;
         ex_o_valid   <= 1'b0;
         ex_o_we_reg  <= 1'b0;
         ex_o_data_rd <= '0;
         ex_o_addr_rd <= '0;
         ex_o_pc      <= '0;
      end else if (ex_i_flush) begin
         state       <= MD_IDLE;
         ex_o_valid  <= 1'b0;
         ex_o_we_reg <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (ex_i_ce) begin
                  funct        <= f_in;
                  ex_o_addr_rd <= ex_i_addr_rd;
                  ex_o_pc      <= ex_i_pc;
                  count        <= '0;
                  acc_hi       <= '0;
                  neg_q        <= a_neg ^ b_neg;
                  neg_r        <= a_neg;
                  // Degenerate divides resolve at accept but still spend one cycle in DIV.
                  if (is_div && (b_zero || ovf)) begin
                     fast         <= 1'b1;
                     ex_o_data_rd <= fast_res;
                     state        <= MD_DIV;
                  end else begin
                     fast   <= 1'b0;
                     acc_lo <= is_div ? mag_a : mag_b;
                     opnd   <= is_div ? mag_b : mag_a;
                     state  <= is_div ? MD_DIV : MD_MUL;
                  end
               end
            end
            MD_MUL, MD_DIV: begin
               if (fast) begin
                  state       <= MD_DONE;
                  ex_o_valid  <= 1'b1;
                  ex_o_we_reg <= (ex_o_addr_rd != '0);
               end else begin
                  acc_hi <= step_hi;
                  acc_lo <= step_lo;
                  count  <= count + 1'b1;
                  if (last) begin
                     state        <= MD_DONE;
                     ex_o_data_rd <= (state == MD_MUL) ? mul_res : div_res;
                     ex_o_valid   <= 1'b1;
                     ex_o_we_reg  <= (ex_o_addr_rd != '0);
                  end
               end
            end
            MD_DONE: begin
               if (!ex_i_stall) begin
                  state       <= MD_IDLE;
                  ex_o_valid  <= 1'b0;
                  ex_o_we_reg <= 1'b0;
               end
            end
            default: state <= MD_IDLE;
         endcase
      end
   end

endmodule
